// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side SRAM bus: FSM states, grant owners and
// transfer-size codes.
package cpu_bus_pkg;

    // Arbiter FSM state: one transaction walks IDLE -> ADDR -> DATA -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    // Which master currently owns the slave port.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    // Transfer size encodings carried on *_size / m_size.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage : cpu_bus_pkg

// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/handshake bundle. The master modport is the side that
// issues requests; the slave modport is the side that accepts them.
interface sram_bus_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req;
    logic             wr;
    logic [1:0]       size;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             addr_ok;
    logic             data_ok;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req, wr, size, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface : sram_bus_arbiter_if

// File: rtl/bus_grant_pick.sv
// Combinational arbitration: data beats inst unless inst has been passed over
// STARVE_LIMIT times in a row, in which case inst wins once. Also produces the
// starvation counter value to store when the grant is taken.
module bus_grant_pick
    import cpu_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             inst_req,
    input  logic             data_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_e           winner,
    output logic [CNT_W-1:0] starve_cnt_next
);

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

    // Winner selection and starvation-counter update for a grant this cycle
    always_comb begin
        winner          = OWN_NONE;
        starve_cnt_next = starve_cnt;
        if (inst_req && (!data_req || starve_cnt == LIMIT_CNT)) begin
            winner          = OWN_INST;
            starve_cnt_next = '0;
        end else if (data_req) begin
            winner = OWN_DATA;
            if (!inst_req) begin
                starve_cnt_next = '0;
            end else if (starve_cnt != LIMIT_CNT) begin
                starve_cnt_next = starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule : bus_grant_pick

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave port between the instruction-fetch master and
// the data-memory master. One transaction is outstanding at a time; the
// winning request is latched so the slave sees stable fields until m_addr_ok.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,        // asynchronous, active-low
    sram_bus_arbiter_if.slave   inst_bus,
    sram_bus_arbiter_if.slave   data_bus,
    sram_bus_arbiter_if.master  m_bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_e             state_q,  state_d;
    owner_e             owner_q,  owner_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               wr_q,     wr_d;
    logic [1:0]         size_q,   size_d;
    logic [WIDTH-1:0]   addr_q,   addr_d;
    logic [WIDTH-1:0]   wdata_q,  wdata_d;

    owner_e             winner;
    logic [CNT_W-1:0]   starve_pick;
    logic               addr_hs;
    logic               data_hs;

    bus_grant_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant_pick (
        .inst_req        (inst_bus.req),
        .data_req        (data_bus.req),
        .starve_cnt      (starve_q),
        .winner          (winner),
        .starve_cnt_next (starve_pick)
    );

    // Slave handshakes only count in the state that expects them; anything
    // else is a protocol error and is ignored.
    assign addr_hs = (state_q == ST_ADDR) && m_bus.addr_ok;
    assign data_hs = (state_q == ST_DATA) && m_bus.data_ok;

    // State register plus latched request fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            wr_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state logic: grant and latch in IDLE, wait for slave handshakes
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (winner == OWN_INST) begin
                    state_d  = ST_ADDR;
                    owner_d  = OWN_INST;
                    starve_d = starve_pick;
                    wr_d     = inst_bus.wr;
                    size_d   = inst_bus.size;
                    addr_d   = inst_bus.addr;
                    wdata_d  = inst_bus.wdata;
                end else if (winner == OWN_DATA) begin
                    state_d  = ST_ADDR;
                    owner_d  = OWN_DATA;
                    starve_d = starve_pick;
                    wr_d     = data_bus.wr;
                    size_d   = data_bus.size;
                    addr_d   = data_bus.addr;
                    wdata_d  = data_bus.wdata;
                end
            end
            ST_ADDR: begin
                if (addr_hs) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_hs) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Slave-side outputs come straight from the latched request
    always_comb begin
        m_bus.req   = (state_q == ST_ADDR);
        m_bus.wr    = wr_q;
        m_bus.size  = size_q;
        m_bus.addr  = addr_q;
        m_bus.wdata = wdata_q;
    end

    // Handshakes are steered to the owner only; read data is broadcast
    always_comb begin
        inst_bus.addr_ok = addr_hs && (owner_q == OWN_INST);
        inst_bus.data_ok = data_hs && (owner_q == OWN_INST);
        data_bus.addr_ok = addr_hs && (owner_q == OWN_DATA);
        data_bus.data_ok = data_hs && (owner_q == OWN_DATA);
        inst_bus.rdata   = m_bus.rdata;
        data_bus.rdata   = m_bus.rdata;
    end

endmodule : sram_bus_arbiter

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter. Inputs change 1 ns after the rising
// edge; outputs are checked 2-3 ns later, well clear of the next edge.
module tb_sram_bus_arbiter;
    import cpu_bus_pkg::*;

    logic clk;
    logic rst;

    sram_bus_arbiter_if #(.WIDTH(32)) inst_if ();
    sram_bus_arbiter_if #(.WIDTH(32)) data_if ();
    sram_bus_arbiter_if #(.WIDTH(32)) m_if ();

    sram_bus_arbiter #(
        .WIDTH        (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inst_bus (inst_if),
        .data_bus (data_if),
        .m_bus    (m_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}
    task automatic chk_oks(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, inst_if.addr_ok, inst_if.data_ok, data_if.addr_ok, data_if.data_ok},
            {28'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_grant [10];
    int         waited;

    initial begin
        // D D D D I D D D D I, encoded as {inst_addr_ok, data_addr_ok}
        exp_grant = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                      2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        rst = 1'b0;
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = SIZE_BYTE; inst_if.addr = 0; inst_if.wdata = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = SIZE_BYTE; data_if.addr = 0; data_if.wdata = 0;
        m_if.addr_ok = 0; m_if.data_ok = 0; m_if.rdata = 32'h0;

        // ---- reset state
        #3;
        chk("rst_m_req", {31'd0, m_if.req}, 32'd0);
        chk_oks("rst_oks", 4'b0000);
        chk("rst_m_addr", m_if.addr, 32'h0);
        chk("rst_m_wdata", m_if.wdata, 32'h0);
        chk("rst_m_size_wr", {29'd0, m_if.size, m_if.wr}, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;

        // ---- single inst read
        inst_if.req = 1; inst_if.wr = 0; inst_if.size = SIZE_WORD; inst_if.addr = 32'hbfc00000;
        #2;
        chk("t1_n_mreq", {31'd0, m_if.req}, 32'd0);
        chk_oks("t1_n_oks", 4'b0000);
        cyc();
        m_if.addr_ok = 1;
        #2;
        chk("t1_n1_mreq", {31'd0, m_if.req}, 32'd1);
        chk("t1_n1_maddr", m_if.addr, 32'hbfc00000);
        chk_oks("t1_n1_oks", 4'b1000);
        cyc();
        inst_if.req = 0; m_if.addr_ok = 0;
        #2;
        chk("t1_n2_mreq", {31'd0, m_if.req}, 32'd0);
        chk_oks("t1_n2_oks", 4'b0000);
        cyc();
        m_if.data_ok = 1; m_if.rdata = 32'h3c080001;
        #2;
        chk_oks("t1_n3_oks", 4'b0100);
        chk("t1_n3_rdata", inst_if.rdata, 32'h3c080001);
        cyc();
        m_if.data_ok = 0;
        #2;
        chk_oks("t1_n4_oks", 4'b0000);

        // ---- inst and data together: data first, inst right after
        cyc();
        inst_if.req = 1; inst_if.addr = 32'hbfc00004;
        data_if.req = 1; data_if.wr = 1; data_if.size = SIZE_WORD;
        data_if.addr = 32'h80001000; data_if.wdata = 32'hdeadbeef;
        #2;
        chk("t2_idle_mreq", {31'd0, m_if.req}, 32'd0);
        cyc();
        #2;
        chk("t2_stall_maddr", m_if.addr, 32'h80001000);
        chk("t2_stall_wdata", m_if.wdata, 32'hdeadbeef);
        chk("t2_stall_size_wr", {29'd0, m_if.size, m_if.wr}, {29'd0, SIZE_WORD, 1'b1});
        chk_oks("t2_stall_oks", 4'b0000);
        cyc();
        m_if.addr_ok = 1;
        #2;
        chk("t2_addr_maddr", m_if.addr, 32'h80001000);
        chk_oks("t2_addr_oks", 4'b0010);
        cyc();
        data_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1;
        #2;
        chk_oks("t2_data_oks", 4'b0001);
        cyc();
        m_if.data_ok = 0;
        #2;
        chk("t2_gap_mreq", {31'd0, m_if.req}, 32'd0);
        cyc();
        m_if.addr_ok = 1;
        #2;
        chk("t2_inst_maddr", m_if.addr, 32'hbfc00004);
        chk_oks("t2_inst_addr_oks", 4'b1000);
        cyc();
        inst_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'h12345678;
        #2;
        chk_oks("t2_inst_data_oks", 4'b0100);
        chk("t2_inst_rdata", inst_if.rdata, 32'h12345678);
        cyc();
        m_if.data_ok = 0;

        // ---- starvation guard, both masters requesting continuously
        inst_if.req = 1; inst_if.wr = 0; inst_if.addr = 32'hbfc00100;
        data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h80003000;
        m_if.addr_ok = 1; m_if.data_ok = 1;
        for (int k = 0; k < 10; k++) begin
            waited = 0;
            #2;
            while (!(inst_if.addr_ok || data_if.addr_ok) && waited < 4) begin
                cyc();
                #2;
                waited++;
            end
            chk($sformatf("t3_grant%0d", k), {30'd0, inst_if.addr_ok, data_if.addr_ok},
                {30'd0, exp_grant[k]});
            cyc();
        end
        inst_if.req = 0; data_if.req = 0;
        #2;
        chk_oks("t3_last_data_oks", 4'b0100);
        cyc();
        m_if.addr_ok = 0; m_if.data_ok = 0;
        #2;
        chk("t3_end_mreq", {31'd0, m_if.req}, 32'd0);

        // ---- slave stalls addr_ok while the data master changes its address
        cyc();
        data_if.req = 1; data_if.wr = 0; data_if.size = SIZE_HALF; data_if.addr = 32'h80002000;
        cyc();
        for (int i = 0; i < 5; i++) begin
            data_if.addr = 32'h80002004 + 32'(i) * 32'd4;
            #2;
            chk($sformatf("t4_stall%0d_mreq", i), {31'd0, m_if.req}, 32'd1);
            chk($sformatf("t4_stall%0d_maddr", i), m_if.addr, 32'h80002000);
            cyc();
        end
        m_if.addr_ok = 1;
        #2;
        chk_oks("t4_addr_oks", 4'b0010);
        chk("t4_size", {30'd0, m_if.size}, {30'd0, SIZE_HALF});
        cyc();
        data_if.req = 0;
        #2;
        chk_oks("t4_spurious_addr_ok", 4'b0000);
        cyc();
        m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'ha5a5a5a5;
        #2;
        chk_oks("t4_data_oks", 4'b0001);
        chk("t4_rdata", data_if.rdata, 32'ha5a5a5a5);
        cyc();
        m_if.data_ok = 0;

        // ---- spurious m_data_ok in IDLE
        cyc();
        m_if.data_ok = 1;
        #2;
        chk_oks("t5_idle_oks", 4'b0000);
        chk("t5_idle_mreq", {31'd0, m_if.req}, 32'd0);
        cyc();
        m_if.data_ok = 0;
        inst_if.req = 1; inst_if.addr = 32'hbfc00010;
        #2;
        chk("t5_still_idle", {31'd0, m_if.req}, 32'd0);
        cyc();
        m_if.addr_ok = 1;
        #2;
        chk_oks("t5_addr_oks", 4'b1000);
        chk("t5_maddr", m_if.addr, 32'hbfc00010);
        cyc();
        inst_if.req = 0; m_if.addr_ok = 0;

        // ---- asynchronous reset in DATA state
        m_if.data_ok = 1;
        #1;
        chk_oks("t6_pre_rst_oks", 4'b0100);
        rst = 1'b0;
        #1;
        chk_oks("t6_rst_oks", 4'b0000);
        chk("t6_rst_mreq", {31'd0, m_if.req}, 32'd0);
        chk("t6_rst_maddr", m_if.addr, 32'h0);
        m_if.data_ok = 0;
        cyc();
        rst = 1'b1;
        inst_if.req = 1; inst_if.addr = 32'hbfc00020;
        #2;
        chk("t6_post_idle", {31'd0, m_if.req}, 32'd0);
        cyc();
        m_if.addr_ok = 1;
        #2;
        chk_oks("t6_post_addr_oks", 4'b1000);
        chk("t6_post_maddr", m_if.addr, 32'hbfc00020);
        cyc();
        inst_if.req = 0; m_if.addr_ok = 0; m_if.data_ok = 1; m_if.rdata = 32'h00000042;
        #2;
        chk_oks("t6_post_data_oks", 4'b0100);
        chk("t6_post_rdata", inst_if.rdata, 32'h00000042);
        cyc();
        m_if.data_ok = 0;
        #2;
        chk_oks("t6_end_oks", 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_bus_arbiter
